dbus_pair_serializer: RTL
=========================

DBUS_PAIR_SERIALIZER -- requirements
Module: dbus_pair_serializer

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-003 SHALL have port dreq_1, input, dbus_req_t: slot-1 data request from the core (older instruction); fields valid, addr[31:0], size[2:0], strobe[3:0], data[31:0].
REQ-004 SHALL have port dreq_2, input, dbus_req_t: slot-2 data request from the core (younger instruction).
REQ-005 SHALL have port dresp_1, output, dbus_resp_t: slot-1 response; fields addr_ok, data_ok, data[31:0].
REQ-006 SHALL have port dresp_2, output, dbus_resp_t: slot-2 response.
REQ-007 SHALL have port dreq, output, dbus_req_t: single serialized request to the memory side.
REQ-008 SHALL have port dresp, input, dbus_resp_t: memory-side response.

Function
REQ-009 SHALL implement FSM states IDLE, ISSUE1, WAIT1, RESP1, ISSUE2, WAIT2, RESP2.
REQ-010 SHALL, in IDLE, register dreq_1 and dreq_2 into buffers buf1 and buf2 with their valid bits; next state is ISSUE1 if dreq_1.valid, else ISSUE2 if dreq_2.valid, else IDLE.
REQ-011 SHALL, in ISSUEn, drive dreq from bufn with valid=1; stay until dresp.addr_ok; on addr_ok go to RESPn if dresp.data_ok is also asserted that cycle, else go to WAITn.
REQ-012 SHALL, in WAITn, drive dreq.valid=0 and go to RESPn on dresp.data_ok, registering dresp.data.
REQ-013 SHALL, in RESPn, pulse dresp_n.addr_ok=1, dresp_n.data_ok=1 and dresp_n.data=captured data for exactly one cycle.
REQ-014 SHALL leave RESP1 for ISSUE2 when buf2 is valid, else for IDLE; SHALL leave RESP2 for IDLE.
REQ-015 SHALL ignore dreq_1/dreq_2 changes outside IDLE; the core holds each request stable until its response pulse.
REQ-016 SHALL preserve program order: slot-1 access always completes downstream before slot-2 is issued, including stores to the same word.
REQ-017 SHALL hold all fields of dresp_1/dresp_2 at 0 outside their RESP cycle, and hold dreq at 0 outside ISSUE states.
REQ-018 SHALL ignore dresp.addr_ok/data_ok in IDLE and RESP states.
REQ-019 SHALL meet minimum latency: single request captured at cycle T gives RESP at T+2; paired requests give RESP1 at T+2 and RESP2 at T+4.

Reset
REQ-020 SHALL, on reset assertion at any time including mid-transaction, force state to IDLE, clear buf1/buf2 valid bits, and drive every output field to 0 immediately.
REQ-021 SHALL drop any downstream transaction in flight at reset; its late data_ok is discarded per REQ-018.

Configuration
REQ-022 SHALL compile the load-merge feature only when macro DBUS_LOAD_MERGE_EN is defined.
REQ-023 SHALL, with DBUS_LOAD_MERGE_EN defined and both buffered requests loads (strobe==0) with equal addr[31:2], go from RESP1 directly to RESP2 with the slot-1 data; no second downstream access is issued.
REQ-024 SHALL, without DBUS_LOAD_MERGE_EN, always issue two downstream accesses for paired requests.

Verification
REQ-025 SHALL test single slot-1 load at 0x0000_1000 with memory answering addr_ok+data_ok in the same cycle with 0xDEAD_BEEF -> dresp_1 pulses at T+2 with data 0xDEAD_BEEF; dresp_2 stays 0.
REQ-026 SHALL test paired store (slot 1, addr 0x2000, strobe 0xF, data 0x1111_1111) and load (slot 2, addr 0x2000) -> store is issued first, then load; the load returns 0x1111_1111 from the memory model.
REQ-027 SHALL test slot-2-only load with addr_ok at T+3 and data_ok at T+5 -> dreq.valid held for cycles T+1..T+3; dresp_2 pulse at T+6.
REQ-028 SHALL test reset asserted while in WAIT1, with memory data_ok arriving after reset -> outputs are 0 asynchronously, state is IDLE, and the stale data_ok produces no response pulse.
REQ-029 SHALL test, with DBUS_LOAD_MERGE_EN defined, loads at 0x3004 and 0x3006 -> exactly one downstream access, RESP1 at T+2, RESP2 at T+3, identical data; without the macro, two accesses occur and RESP2 is at T+4.

Source files
------------

// File: rtl/dbus_pair_serializer.sv
`default_nettype none
// ============================================================================
// Module   : dbus_pair_serializer
// Purpose  : Serializes a dual-issue core's two data-bus requests onto one
//            memory port, slot 1 first. The optional load-merge path is built
//            only when DBUS_LOAD_MERGE_EN is defined.
// Revision : 1.0
// ============================================================================

typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [3:0]  strobe;
    logic [31:0] data;
} dbus_req_t;

typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
} dbus_resp_t;

module dbus_pair_serializer (
    input  logic       clk,
    input  logic       reset,
    input  dbus_req_t  dreq_1,
    input  dbus_req_t  dreq_2,
    output dbus_resp_t dresp_1,
    output dbus_resp_t dresp_2,
    output dbus_req_t  dreq,
    input  dbus_resp_t dresp
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE1 = 3'd1,
        WAIT1  = 3'd2,
        RESP1  = 3'd3,
        ISSUE2 = 3'd4,
        WAIT2  = 3'd5,
        RESP2  = 3'd6
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    dbus_req_t   r_buf1;
    dbus_req_t   r_buf2;
    logic [31:0] r_data;
    logic        w_capture;
    logic        w_merge;

`ifdef DBUS_LOAD_MERGE_EN
    // Two loads of the same word: the slot-1 data answers slot 2 as well.
    assign w_merge = r_buf1.valid && r_buf2.valid &&
                     (r_buf1.strobe == 4'd0) && (r_buf2.strobe == 4'd0) &&
                     (r_buf1.addr[31:2] == r_buf2.addr[31:2]);
`else
    assign w_merge = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_buf1  <= '0;
            r_buf2  <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == IDLE) begin
                r_buf1 <= dreq_1;
                r_buf2 <= dreq_2;
            end
            if (w_capture) begin
                r_data <= dresp.data;
            end
        end
    end

    // Outputs are purely state-decoded, so reset zeroes them without a clock.
    always_comb begin
        w_next_state = r_state;
        w_capture    = 1'b0;
        dreq         = '0;
        dresp_1      = '0;
        dresp_2      = '0;
        case (r_state)
            IDLE: begin
                if (dreq_1.valid) begin
                    w_next_state = ISSUE1;
                end else if (dreq_2.valid) begin
                    w_next_state = ISSUE2;
                end
            end
            ISSUE1: begin
                dreq       = r_buf1;
                dreq.valid = 1'b1;
                if (dresp.addr_ok) begin
                    if (dresp.data_ok) begin
                        w_capture    = 1'b1;
                        w_next_state = RESP1;
                    end else begin
                        w_next_state = WAIT1;
                    end
                end
            end
            WAIT1: begin
                if (dresp.data_ok) begin
                    w_capture    = 1'b1;
                    w_next_state = RESP1;
                end
            end
            RESP1: begin
                dresp_1.addr_ok = 1'b1;
                dresp_1.data_ok = 1'b1;
                dresp_1.data    = r_data;
                if (w_merge) begin
                    w_next_state = RESP2;
                end else if (r_buf2.valid) begin
                    w_next_state = ISSUE2;
                end else begin
                    w_next_state = IDLE;
                end
            end
            ISSUE2: begin
                dreq       = r_buf2;
                dreq.valid = 1'b1;
                if (dresp.addr_ok) begin
                    if (dresp.data_ok) begin
                        w_capture    = 1'b1;
                        w_next_state = RESP2;
                    end else begin
                        w_next_state = WAIT2;
                    end
                end
            end
            WAIT2: begin
                if (dresp.data_ok) begin
                    w_capture    = 1'b1;
                    w_next_state = RESP2;
                end
            end
            RESP2: begin
                dresp_2.addr_ok = 1'b1;
                dresp_2.data_ok = 1'b1;
                dresp_2.data    = r_data;
                w_next_state    = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire
